// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - sequential shift-add WIDTH x WIDTH multiplier, signed/unsigned per operation
module mult_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   y
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH:0]   acc;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     upper_sum;
  logic [2*WIDTH:0]   acc_next;

  // Magnitude of the most-negative value wraps to 2^(WIDTH-1), which is correct as unsigned.
  always_comb begin
    mag_a     = (signed_mode && a[WIDTH-1]) ? -a : a;
    mag_b     = (signed_mode && b[WIDTH-1]) ? -b : b;
    upper_sum = acc[2*WIDTH:WIDTH] + (mplier[0] ? {1'b0, mcand} : '0);
    acc_next  = {upper_sum, acc[WIDTH-1:0]} >> 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      y      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            y     <= neg ? -acc_next[2*WIDTH-1:0] : acc_next[2*WIDTH-1:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - directed checks of mult_seq at WIDTH=4 plus a WIDTH=8 reference sweep
module tb_mult_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start4 = 1'b0, sm4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4;
  logic [7:0] y4;

  logic       start8 = 1'b0, sm8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8;
  logic [15:0] y8;

  int n_checks = 0;
  int n_fail   = 0;
  int dones8   = 0;

  mult_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .y(y4)
  );

  mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .y(y8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && done8) dones8 <= dones8 + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in the cycle after the start edge; k = edges from start edge to done edge.
  task automatic wait_done4(output int k, output int bc);
    k  = 0;
    bc = 0;
    while (!done4 && k < 40) begin
      if (busy4) bc++;
      tick();
      k++;
    end
  endtask

  task automatic op4(input string tag, input logic sm, input logic [3:0] a, input logic [3:0] b,
                     input logic [7:0] exp);
    int k, bc;
    sm4 = sm; a4 = a; b4 = b; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    wait_done4(k, bc);
    check({tag, "_lat"}, k, 4);
    check({tag, "_y"}, y4, exp);
  endtask

  initial begin
    int k, bc, quiet;
    logic [15:0] exp16;
    int sa, sb;

    tick(); tick();
    rst = 1'b0;
    check("reset_busy", busy4, 0);
    check("reset_done", done4, 0);
    check("reset_y", y4, 0);

    // Unsigned max with busy duration
    sm4 = 1'b0; a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("umax_busy_after_start", busy4, 1);
    wait_done4(k, bc);
    check("umax_lat", k, 4);
    check("umax_busy_cycles", bc, 4);
    check("umax_y", y4, 8'hE1);
    check("umax_done_busy_excl", busy4, 0);
    tick();
    check("umax_done_single", done4, 0);
    check("umax_y_hold", y4, 8'hE1);

    op4("s_m8xm8", 1'b1, 4'h8, 4'h8, 8'h40);
    op4("s_m3x5",  1'b1, 4'hD, 4'h5, 8'hF1);
    op4("s_7xm8",  1'b1, 4'h7, 4'h8, 8'hC8);
    op4("s_0xm5",  1'b1, 4'h0, 4'hB, 8'h00);
    op4("u_8x8",   1'b0, 4'h8, 4'h8, 8'h40);

    // Back-to-back: start held high, second pair presented while busy
    sm4 = 1'b0; a4 = 4'd3; b4 = 4'd4; start4 = 1'b1;
    tick();
    a4 = 4'd9; b4 = 4'd2;
    wait_done4(k, bc);
    check("b2b_first_lat", k, 4);
    check("b2b_first_y", y4, 8'd12);
    tick();
    start4 = 1'b0;
    check("b2b_reaccept_busy", busy4, 1);
    wait_done4(k, bc);
    check("b2b_second_lat", k, 4);
    check("b2b_second_y", y4, 8'd18);

    // Start while busy must be ignored
    sm4 = 1'b0; a4 = 4'd6; b4 = 4'd7; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    wait_done4(k, bc);
    check("ign_lat", k, 2);
    check("ign_y", y4, 8'd42);
    quiet = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done4) quiet++;
    end
    check("ign_extra_done", quiet, 0);
    check("ign_y_hold", y4, 8'd42);

    // Reset in the middle of 5*5
    sm4 = 1'b0; a4 = 4'd5; b4 = 4'd5; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", busy4, 0);
    check("rst_mid_done", done4, 0);
    check("rst_mid_y", y4, 0);
    quiet = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done4) quiet++;
    end
    check("rst_mid_no_done", quiet, 0);
    op4("rst_after_5x5", 1'b0, 4'd5, 4'd5, 8'd25);

    // WIDTH=8 sweep against the bench's own signed/unsigned product
    for (int i = 0; i < 1000; i++) begin
      sm8 = 1'($urandom_range(0, 1));
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      if (i == 0) begin a8 = 8'h80; b8 = 8'h80; sm8 = 1'b1; end
      if (i == 1) begin a8 = 8'hFF; b8 = 8'hFF; sm8 = 1'b0; end
      sa = sm8 ? int'($signed(a8)) : int'(a8);
      sb = sm8 ? int'($signed(b8)) : int'(b8);
      exp16 = 16'(sa * sb);
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      k = 0;
      while (!done8 && k < 40) begin
        tick();
        k++;
      end
      check("w8_lat", k, 8);
      check("w8_y", y8, exp16);
    end
    tick();
    check("w8_done_count", dones8, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
